cr_kme_fifo_writer: RTL and testbench
=====================================

# cr_kme_fifo_writer

Producer-side adapter that feeds a KME stall-based FIFO write port (fifo_in / fifo_in_valid / fifo_in_stall). It accepts words from an upstream valid/ready source, holds them in a 2-entry skid buffer, and presents them to the FIFO without ever writing while stall is asserted. This keeps overflow from occurring and breaks every combinational path from fifo_in_stall to upstream ready. It also keeps a running word count and a stall watchdog for KME debug CSRs.

## Interface
Parameters:
- DATA_W, default 106: data width; matches the FIFO payload width.
- TIMEOUT, default 1024: number of consecutive blocked cycles before stall_timeout sets. Legal range is 1 to 65535.

Ports:
- clk, input, 1: the only clock.
- rst_n, input, 1: reset, synchronous to clk, active-low.
- src_valid, input, 1: upstream word valid.
- src_data, input, DATA_W: upstream word.
- src_ready, output, 1: upstream may transfer this cycle. Registered.
- fifo_in, output, DATA_W: FIFO write data. Registered.
- fifo_in_valid, output, 1: FIFO write enable. Registered.
- fifo_in_stall, input, 1: FIFO has no free slot. A write in a cycle where this is high is illegal.
- clr_err, input, 1: single-cycle clear for stall_timeout.
- sent_cnt, output, 32: count of words written to the FIFO. Wraps.
- stall_timeout, output, 1: sticky watchdog flag.

## Operation
- Skid buffer state machine, occupancy occ:
  - EMPTY (0), ONE (1), FULL (2).
  - Head entry drives fifo_in. A second entry holds overflow.
- Handshakes:
  - push = src_valid & src_ready.
  - pop = fifo_in_valid & ~fifo_in_stall.
- Transitions:
  - EMPTY + push → ONE.
  - ONE + push only → FULL.
  - ONE + pop only → EMPTY.
  - ONE + push & pop → ONE; the new word becomes head.
  - FULL + pop → ONE; the second entry moves to head.
  - FULL + push cannot occur, because src_ready = 0.
- Outputs:
  - fifo_in_valid = (occ != EMPTY).
  - src_ready = (occ != FULL). Both are decoded from registered state only.
- Ordering: words leave in strict arrival order; the buffer never drops or duplicates a word.
- fifo_in holds its value while fifo_in_valid & fifo_in_stall, and does not change until a pop.
- sent_cnt increments by 1 on every pop and wraps from 0xFFFF_FFFF to 0.
- Watchdog:
  - blk_cnt (16-bit) increments each cycle that fifo_in_valid & fifo_in_stall.
  - It clears to 0 on any cycle without that condition.
  - When blk_cnt reaches TIMEOUT - 1 while still blocked, stall_timeout sets on the next edge.
  - blk_cnt saturates at TIMEOUT - 1.
- clr_err clears stall_timeout.
  - If clr_err and the set condition occur in the same cycle, set wins.
  - clr_err does not affect blk_cnt.

## Timing
- Reset (synchronous, rst_n low at a clk edge) drives every register to its reset value:
  - occ = EMPTY, so fifo_in_valid = 0 and src_ready = 1.
  - fifo_in = 0, sent_cnt = 0, blk_cnt = 0, stall_timeout = 0.
- Reset mid-operation discards buffered words. Outputs take their reset values on the cycle after the sampling edge.
- Latency: a word pushed at edge N into EMPTY shows on fifo_in with fifo_in_valid = 1 after edge N.
- Throughput: one word per cycle while stall stays low.
- fifo_in_stall is sampled combinationally only for pop. It never reaches src_ready in the same cycle.
- After a stall assertion, at most one additional upstream word is accepted (ONE → FULL). src_ready then drops the cycle after occ reaches FULL.
- Stall deasserting with occ = FULL: pop that cycle, occ becomes ONE, and src_ready rises on the next cycle.
- With TIMEOUT = T and stall held high with data pending from cycle 0, stall_timeout is first high in cycle T.

## Test plan
- Reset, then stream 8 words 0x1..0x8 with stall = 0 → fifo_in presents 0x1..0x8 on consecutive cycles, one cycle after each push. sent_cnt = 8 and src_ready stays 1.
- Push 0xA, then 0xB, with stall raised the cycle 0xA appears:
  - occ reaches FULL, src_ready = 0, and fifo_in holds 0xA.
  - After stall drops, 0xA and then 0xB are written.
  - No write occurs while stall = 1.
- Continuous push with stall toggling randomly for 1000 cycles → the scoreboard sees every word exactly once and in order. sent_cnt equals the number of pops.
- TIMEOUT = 4, data pending, stall held high for 10 cycles → stall_timeout rises in cycle 4 and stays high after stall drops. A clr_err pulse then clears it.
- Same setup with clr_err asserted in the cycle the flag would set → stall_timeout = 1.
- Reset asserted while occ = FULL → the next cycle shows fifo_in_valid = 0, src_ready = 1, sent_cnt = 0. Buffered words never reach the FIFO.

Source files
------------

// File: rtl/cr_kme_fifo_writer.sv
// Producer-side adapter for a KME stall-based FIFO write port: a 2-entry skid
// buffer that never writes under stall, plus a sent-word counter and stall watchdog.
module cr_kme_fifo_writer #(
  parameter int DATA_W  = 106,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic [DATA_W-1:0] fifo_in,
  output logic              fifo_in_valid,
  input  logic              fifo_in_stall,
  input  logic              clr_err,
  output logic [31:0]       sent_cnt,
  output logic              stall_timeout
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  localparam logic [15:0] BLK_MAX = 16'(TIMEOUT - 1);

  occ_e              occ_r;
  occ_e              occ_nxt_s;
  logic [DATA_W-1:0] head_r;
  logic [DATA_W-1:0] head_nxt_s;
  logic [DATA_W-1:0] tail_r;
  logic [DATA_W-1:0] tail_nxt_s;
  logic              valid_r;
  logic              ready_r;
  logic              push_s;
  logic              pop_s;
  logic              blocked_s;
  logic              set_s;
  logic [15:0]       blk_r;
  logic [31:0]       cnt_r;
  logic              flag_r;

  // valid/ready come from flops, so fifo_in_stall never reaches src_ready combinationally
  assign push_s    = src_valid & ready_r;
  assign pop_s     = valid_r & ~fifo_in_stall;
  assign blocked_s = valid_r & fifo_in_stall;
  assign set_s     = blocked_s & (blk_r == BLK_MAX);

  // Skid buffer next-state and entry data
  always_comb begin
    occ_nxt_s  = occ_r;
    head_nxt_s = head_r;
    tail_nxt_s = tail_r;
    case (occ_r)
      EMPTY: begin
        if (push_s) begin
          occ_nxt_s  = ONE;
          head_nxt_s = src_data;
        end else begin
          occ_nxt_s  = EMPTY;
        end
      end
      ONE: begin
        if (push_s && pop_s) begin
          head_nxt_s = src_data;
        end else if (push_s) begin
          tail_nxt_s = src_data;
          occ_nxt_s  = FULL;
        end else if (pop_s) begin
          occ_nxt_s  = EMPTY;
        end else begin
          occ_nxt_s  = ONE;
        end
      end
      FULL: begin
        if (pop_s) begin
          head_nxt_s = tail_r;
          occ_nxt_s  = ONE;
        end else begin
          occ_nxt_s  = FULL;
        end
      end
      default: begin
        occ_nxt_s = EMPTY;
      end
    endcase
  end

  // Buffer state, entries and the registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_r   <= EMPTY;
      head_r  <= '0;
      tail_r  <= '0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      occ_r   <= occ_nxt_s;
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      valid_r <= (occ_nxt_s != EMPTY);
      ready_r <= (occ_nxt_s != FULL);
    end
  end

  // Running count of words written to the FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= 32'd0;
    end else if (pop_s) begin
      cnt_r <= cnt_r + 32'd1;
    end
  end

  // Stall watchdog: saturating blocked-cycle counter and sticky flag (set beats clear)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_r  <= 16'd0;
      flag_r <= 1'b0;
    end else begin
      if (!blocked_s) begin
        blk_r <= 16'd0;
      end else if (blk_r != BLK_MAX) begin
        blk_r <= blk_r + 16'd1;
      end
      if (set_s) begin
        flag_r <= 1'b1;
      end else if (clr_err) begin
        flag_r <= 1'b0;
      end
    end
  end

  assign src_ready     = ready_r;
  assign fifo_in_valid = valid_r;
  assign fifo_in       = head_r;
  assign sent_cnt      = cnt_r;
  assign stall_timeout = flag_r;

endmodule

// File: tb/tb_cr_kme_fifo_writer.sv
// Randomized self-checking bench for cr_kme_fifo_writer against a queue-based
// reference model of the buffer, counter and watchdog.
`timescale 1ns/1ps
module tb_cr_kme_fifo_writer;

  localparam int DATA_W  = 106;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic [DATA_W-1:0] fifo_in;
  logic              fifo_in_valid;
  logic              fifo_in_stall;
  logic              clr_err;
  logic [31:0]       sent_cnt;
  logic              stall_timeout;

  cr_kme_fifo_writer #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .fifo_in(fifo_in), .fifo_in_valid(fifo_in_valid),
    .fifo_in_stall(fifo_in_stall), .clr_err(clr_err), .sent_cnt(sent_cnt),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: words accepted but not yet written, in arrival order
  logic [DATA_W-1:0] m_q[$];
  logic [31:0]       m_sent;
  int                m_blk;
  bit                m_flag;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("src_ready", 128'(src_ready), 128'(m_q.size() < 2));
    check("fifo_in_valid", 128'(fifo_in_valid), 128'(m_q.size() != 0));
    if (m_q.size() != 0) check("fifo_in", 128'(fifo_in), 128'(m_q[0]));
    check("sent_cnt", 128'(sent_cnt), 128'(m_sent));
    check("stall_timeout", 128'(stall_timeout), 128'(m_flag));
  endtask

  // apply inputs for one clock, advance the model, then check outputs after the edge
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic st, input logic clr);
    bit push, pop, blocked, set;
    src_valid = v; src_data = d; fifo_in_stall = st; clr_err = clr;
    push    = v && (m_q.size() < 2);
    pop     = (m_q.size() != 0) && !st;
    blocked = (m_q.size() != 0) && st;
    set     = blocked && (m_blk == TIMEOUT - 1);
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete(); m_sent = 32'd0; m_blk = 0; m_flag = 1'b0;
    end else begin
      if (pop) begin
        void'(m_q.pop_front());
        m_sent = m_sent + 32'd1;
      end
      if (push) m_q.push_back(d);
      if (!blocked) m_blk = 0;
      else if (m_blk < TIMEOUT - 1) m_blk = m_blk + 1;
      if (set) m_flag = 1'b1;
      else if (clr) m_flag = 1'b0;
    end
    #1;
    check_outputs();
  endtask

  function automatic logic [DATA_W-1:0] rnd_word();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DATA_W-1:0] wa, wb;
    int first;
    rst_n = 1'b0; src_valid = 1'b0; src_data = '0; fifo_in_stall = 1'b0; clr_err = 1'b0;
    m_sent = 32'd0; m_blk = 0; m_flag = 1'b0;

    // reset values
    do_reset();
    check("rst_fifo_in", 128'(fifo_in), 128'd0);
    check("rst_valid", 128'(fifo_in_valid), 128'd0);
    check("rst_ready", 128'(src_ready), 128'd1);

    // stream 1..8 without stall
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);
      check("stream_word", 128'(fifo_in), 128'(i));
      check("stream_ready", 128'(src_ready), 128'd1);
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("stream_sent", 128'(sent_cnt), 128'd8);

    // skid: stall rises as 0xA appears, 0xB lands in the second entry
    wa = DATA_W'(32'hA); wb = DATA_W'(32'hB);
    cycle(1'b1, wa, 1'b0, 1'b0);
    cycle(1'b1, wb, 1'b1, 1'b0);
    check("skid_ready", 128'(src_ready), 128'd0);
    check("skid_head", 128'(fifo_in), 128'hA);
    cycle(1'b1, DATA_W'(32'hC), 1'b1, 1'b0);
    check("skid_hold", 128'(fifo_in), 128'hA);
    check("skid_sent", 128'(sent_cnt), 128'd8);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("skid_second", 128'(fifo_in), 128'hB);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("skid_sent2", 128'(sent_cnt), 128'd10);

    // random stall with continuous push
    for (int i = 0; i < 1000; i++)
      cycle(1'b1, rnd_word(), 1'(($urandom() % 3) == 0), 1'(($urandom() % 16) == 0));
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    check("drained", 128'(m_q.size()), 128'd0);

    // watchdog timing, stickiness and clear
    do_reset();
    cycle(1'b1, rnd_word(), 1'b1, 1'b0);
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      if (stall_timeout && first == 0) first = i;
    end
    check("wd_first", 128'(first), 128'(TIMEOUT));
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("wd_sticky", 128'(stall_timeout), 128'd1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("wd_clear", 128'(stall_timeout), 128'd0);

    // set wins over a simultaneous clear
    do_reset();
    cycle(1'b1, rnd_word(), 1'b1, 1'b0);
    for (int i = 1; i < TIMEOUT; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("wd_pre", 128'(stall_timeout), 128'd0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("wd_set_wins", 128'(stall_timeout), 128'd1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // reset while FULL drops buffered words
    cycle(1'b1, rnd_word(), 1'b1, 1'b0);
    cycle(1'b1, rnd_word(), 1'b1, 1'b0);
    check("full_ready", 128'(src_ready), 128'd0);
    rst_n = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("rstfull_valid", 128'(fifo_in_valid), 128'd0);
    check("rstfull_ready", 128'(src_ready), 128'd1);
    check("rstfull_sent", 128'(sent_cnt), 128'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    check("rstfull_nowrite", 128'(sent_cnt), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
